// File: rtl/pi_pipeline_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : pi_pipeline_mc_if
// Purpose  : Sample-in / result-out bus of the multi-channel PI pipeline.
//            Integrator clamp ports exist only with PI_INTEGRATOR_CLAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface pi_pipeline_mc_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int INPUT_WIDTH  = 18,
    parameter int OUTPUT_WIDTH = 32
);
    localparam int c_CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic                           in_valid;
    logic                           in_ready;
    logic        [c_CH_W-1:0]       in_ch;
    logic signed [INPUT_WIDTH-1:0]  setpoint;
    logic signed [INPUT_WIDTH-1:0]  actual;
    logic signed [OUTPUT_WIDTH-1:0] kp;
    logic signed [OUTPUT_WIDTH-1:0] ki;
    logic signed [OUTPUT_WIDTH-1:0] sat_lower;
    logic signed [OUTPUT_WIDTH-1:0] sat_upper;
`ifdef PI_INTEGRATOR_CLAMP_EN
    logic signed [OUTPUT_WIDTH-1:0] integ_lower;
    logic signed [OUTPUT_WIDTH-1:0] integ_upper;
`endif
    logic                           integ_clear;
    logic        [c_CH_W-1:0]       integ_clear_ch;
    logic                           out_valid;
    logic        [c_CH_W-1:0]       out_ch;
    logic signed [OUTPUT_WIDTH-1:0] pi_result;
    logic signed [OUTPUT_WIDTH-1:0] integral_result;

    modport master (
`ifdef PI_INTEGRATOR_CLAMP_EN
        output integ_lower, integ_upper,
`endif
        output in_valid, in_ch, setpoint, actual, kp, ki, sat_lower, sat_upper,
        output integ_clear, integ_clear_ch,
        input  in_ready, out_valid, out_ch, pi_result, integral_result
    );

    modport slave (
`ifdef PI_INTEGRATOR_CLAMP_EN
        input  integ_lower, integ_upper,
`endif
        input  in_valid, in_ch, setpoint, actual, kp, ki, sat_lower, sat_upper,
        input  integ_clear, integ_clear_ch,
        output in_ready, out_valid, out_ch, pi_result, integral_result
    );
endinterface
`default_nettype wire

// File: rtl/pi_pipeline_mc.sv
`default_nettype none
// ============================================================================
// Module   : pi_pipeline_mc
// Purpose  : Six-stage multi-channel PI controller sharing one datapath, with
//            an internal per-channel integrator bank. Optional integrator
//            clamp ports enabled by PI_INTEGRATOR_CLAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pi_pipeline_mc #(
    parameter int NUM_CHANNELS = 4,
    parameter int INPUT_WIDTH  = 18,
    parameter int OUTPUT_WIDTH = 32,
    parameter int FRAC_BITS    = 0
) (
    input  logic            clk,
    input  logic            rst,
    pi_pipeline_mc_if.slave bus
);
    localparam int c_CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int c_W    = OUTPUT_WIDTH;
    localparam int c_PW   = 2 * OUTPUT_WIDTH;
    localparam int c_SW   = 2 * OUTPUT_WIDTH + 1;

    localparam logic [c_CH_W:0]          c_NCH     = (c_CH_W + 1)'(NUM_CHANNELS);
    localparam logic [c_CH_W-1:0]        c_LAST_CH = c_CH_W'(NUM_CHANNELS - 1);
    localparam logic signed [c_W-1:0]    c_IMAX    = {1'b0, {(c_W - 1){1'b1}}};
    localparam logic signed [c_W-1:0]    c_IMIN    = {1'b1, {(c_W - 1){1'b0}}};

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SWEEP = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;

    logic [1:0]        r_state;
    logic [c_CH_W-1:0] r_sweep_ch;

    logic signed [c_W-1:0] r_bank [NUM_CHANNELS];

    logic w_accept;
    logic w_clear;
    logic signed [c_W-1:0] w_act_x;
    logic signed [c_W-1:0] w_sp_x;
    logic signed [c_W-1:0] w_e;
    logic signed [c_W-1:0] w_rd_integ;
    logic signed [c_W-1:0] w_s2_base;
    logic signed [c_W:0]   w_s2_sum;
    logic signed [c_W-1:0] w_s2_sat;
    logic signed [c_W-1:0] w_s2_integ;
    logic signed [c_SW-1:0] w_s5_full;
    logic signed [c_SW-1:0] w_s6_lo_x;
    logic signed [c_SW-1:0] w_s6_hi_x;
    logic signed [c_W-1:0]  w_s6_pi;

    // S1
    logic                  r_s1_valid;
    logic [c_CH_W-1:0]     r_s1_ch;
    logic signed [c_W-1:0] r_s1_e, r_s1_integ, r_s1_kp, r_s1_ki, r_s1_lo, r_s1_hi;
`ifdef PI_INTEGRATOR_CLAMP_EN
    logic signed [c_W-1:0] r_s1_ilo, r_s1_ihi;
`endif
    // S2
    logic                  r_s2_valid;
    logic [c_CH_W-1:0]     r_s2_ch;
    logic signed [c_W-1:0] r_s2_e, r_s2_integ, r_s2_kp, r_s2_ki, r_s2_lo, r_s2_hi;
    // S3 / S4
    logic                   r_s3_valid, r_s4_valid;
    logic [c_CH_W-1:0]      r_s3_ch, r_s4_ch;
    logic signed [c_W-1:0]  r_s3_integ, r_s3_lo, r_s3_hi;
    logic signed [c_W-1:0]  r_s4_integ, r_s4_lo, r_s4_hi;
    logic signed [c_PW-1:0] r_s3_p, r_s3_i, r_s4_p, r_s4_i;
    // S5
    logic                   r_s5_valid;
    logic [c_CH_W-1:0]      r_s5_ch;
    logic signed [c_W-1:0]  r_s5_integ, r_s5_lo, r_s5_hi;
    logic signed [c_SW-1:0] r_s5_sum;
    // S6 / outputs
    logic                  r_out_valid;
    logic [c_CH_W-1:0]     r_out_ch;
    logic signed [c_W-1:0] r_out_pi;
    logic signed [c_W-1:0] r_out_integ;

    function automatic logic signed [c_W-1:0] f_clamp(
        input logic signed [c_W-1:0] v,
        input logic signed [c_W-1:0] lo,
        input logic signed [c_W-1:0] hi
    );
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

    // Bank is zeroed one entry per cycle after reset before samples are taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_sweep_ch <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_state    <= c_ST_SWEEP;
                    r_sweep_ch <= '0;
                end
                c_ST_SWEEP: begin
                    r_sweep_ch <= r_sweep_ch + 1'b1;
                    if (r_sweep_ch == c_LAST_CH) r_state <= c_ST_RUN;
                end
                c_ST_RUN: r_state <= c_ST_RUN;
                default:  r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready = (r_state == c_ST_RUN);
    assign w_accept = bus.in_valid && bus.in_ready && ({1'b0, bus.in_ch} < c_NCH);
    assign w_clear  = bus.integ_clear && (r_state == c_ST_RUN) &&
                      ({1'b0, bus.integ_clear_ch} < c_NCH);

    assign w_act_x = c_W'(bus.actual);
    assign w_sp_x  = c_W'(bus.setpoint);
    assign w_e     = w_act_x - w_sp_x;

    // A clear at this edge zeroes the S1 sample's base; its S2 result still lands.
    always_comb begin
        w_s2_base = r_s1_integ;
        if (w_clear && (bus.integ_clear_ch == r_s1_ch)) w_s2_base = '0;
        w_s2_sum = {w_s2_base[c_W-1], w_s2_base} + {r_s1_e[c_W-1], r_s1_e};
        if (w_s2_sum[c_W] != w_s2_sum[c_W-1]) w_s2_sat = w_s2_sum[c_W] ? c_IMIN : c_IMAX;
        else                                  w_s2_sat = w_s2_sum[c_W-1:0];
`ifdef PI_INTEGRATOR_CLAMP_EN
        w_s2_integ = f_clamp(w_s2_sat, r_s1_ilo, r_s1_ihi);
`else
        w_s2_integ = w_s2_sat;
`endif
    end

    // The newest value wins: S2 write in flight, then a same-edge clear, then the bank.
    always_comb begin
        w_rd_integ = r_bank[bus.in_ch];
        if (w_clear && (bus.integ_clear_ch == bus.in_ch)) w_rd_integ = '0;
        if (r_s1_valid && (r_s1_ch == bus.in_ch))         w_rd_integ = w_s2_integ;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == c_ST_SWEEP) begin
                r_bank[r_sweep_ch] <= '0;
            end else begin
                if (w_clear)    r_bank[bus.integ_clear_ch] <= '0;
                if (r_s1_valid) r_bank[r_s1_ch] <= w_s2_integ;
            end
        end
    end

    assign w_s5_full = {r_s4_p[c_PW-1], r_s4_p} + {r_s4_i[c_PW-1], r_s4_i};

    assign w_s6_lo_x = c_SW'(r_s5_lo);
    assign w_s6_hi_x = c_SW'(r_s5_hi);
    always_comb begin
        if (r_s5_lo > r_s5_hi)         w_s6_pi = r_s5_hi;
        else if (r_s5_sum > w_s6_hi_x) w_s6_pi = r_s5_hi;
        else if (r_s5_sum < w_s6_lo_x) w_s6_pi = r_s5_lo;
        else                           w_s6_pi = r_s5_sum[c_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s3_valid  <= 1'b0;
            r_s4_valid  <= 1'b0;
            r_s5_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_pi    <= '0;
            r_out_integ <= '0;
        end else begin
            r_s1_valid  <= w_accept;
            r_s2_valid  <= r_s1_valid;
            r_s3_valid  <= r_s2_valid;
            r_s4_valid  <= r_s3_valid;
            r_s5_valid  <= r_s4_valid;
            r_out_valid <= r_s5_valid;
            if (r_s5_valid) begin
                r_out_ch    <= r_s5_ch;
                r_out_pi    <= w_s6_pi;
                r_out_integ <= r_s5_integ;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_s1_ch    <= bus.in_ch;
        r_s1_e     <= w_e;
        r_s1_integ <= w_rd_integ;
        r_s1_kp    <= bus.kp;
        r_s1_ki    <= bus.ki;
        r_s1_lo    <= bus.sat_lower;
        r_s1_hi    <= bus.sat_upper;
`ifdef PI_INTEGRATOR_CLAMP_EN
        r_s1_ilo   <= bus.integ_lower;
        r_s1_ihi   <= bus.integ_upper;
`endif
        r_s2_ch    <= r_s1_ch;
        r_s2_e     <= r_s1_e;
        r_s2_integ <= w_s2_integ;
        r_s2_kp    <= r_s1_kp;
        r_s2_ki    <= r_s1_ki;
        r_s2_lo    <= r_s1_lo;
        r_s2_hi    <= r_s1_hi;

        r_s3_ch    <= r_s2_ch;
        r_s3_integ <= r_s2_integ;
        r_s3_lo    <= r_s2_lo;
        r_s3_hi    <= r_s2_hi;
        r_s3_p     <= c_PW'(r_s2_kp) * c_PW'(r_s2_e);
        r_s3_i     <= c_PW'(r_s2_ki) * c_PW'(r_s2_integ);

        r_s4_ch    <= r_s3_ch;
        r_s4_integ <= r_s3_integ;
        r_s4_lo    <= r_s3_lo;
        r_s4_hi    <= r_s3_hi;
        r_s4_p     <= r_s3_p;
        r_s4_i     <= r_s3_i;

        r_s5_ch    <= r_s4_ch;
        r_s5_integ <= r_s4_integ;
        r_s5_lo    <= r_s4_lo;
        r_s5_hi    <= r_s4_hi;
        r_s5_sum   <= w_s5_full >>> FRAC_BITS;
    end

    assign bus.out_valid       = r_out_valid;
    assign bus.out_ch          = r_out_ch;
    assign bus.pi_result       = r_out_pi;
    assign bus.integral_result = r_out_integ;
endmodule
`default_nettype wire

// File: tb/tb_pi_pipeline_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pi_pipeline_mc
// Purpose  : Scoreboard bench for pi_pipeline_mc against a per-channel
//            arithmetic model; honours PI_INTEGRATOR_CLAMP_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pi_pipeline_mc;
    localparam int N   = 4;
    localparam int CHW = 2;
    localparam int IW  = 18;
    localparam int OW  = 32;
    localparam longint IMAX = 64'sd2147483647;
    localparam longint IMIN = -64'sd2147483648;

    typedef struct {
        int     ch;
        longint e, kp, ki, lo, hi, ilo, ihi;
        int     acc;
    } smp_t;

    typedef struct {
        int     ch;
        longint pi;
        longint integ;
        int     due;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_err;
    int   run_edge;

    exp_t   q[$];
    exp_t   mx;
    smp_t   pend;
    bit     pend_v;
    longint integ [N];

    pi_pipeline_mc_if #(.NUM_CHANNELS(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();
    pi_pipeline_mc_if #(.NUM_CHANNELS(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus4 ();

    pi_pipeline_mc #(.NUM_CHANNELS(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .FRAC_BITS(0))
        dut (.clk(clk), .rst(rst), .bus(bus));
    pi_pipeline_mc #(.NUM_CHANNELS(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .FRAC_BITS(4))
        dut_f4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Integration of a sample happens one edge after acceptance, after any clear at that edge.
    function automatic void integrate(input smp_t s);
        longint i;
        longint sum;
        longint pi;
        i = integ[s.ch] + s.e;
        if (i > IMAX) i = IMAX;
        else if (i < IMIN) i = IMIN;
`ifdef PI_INTEGRATOR_CLAMP_EN
        if (i > s.ihi) i = s.ihi;
        else if (i < s.ilo) i = s.ilo;
`endif
        integ[s.ch] = i;
        sum = (s.kp * s.e + s.ki * i) >>> 0;
        if (s.lo > s.hi)      pi = s.hi;
        else if (sum > s.hi)  pi = s.hi;
        else if (sum < s.lo)  pi = s.lo;
        else                  pi = sum;
        q.push_back('{ch: s.ch, pi: pi, integ: i, due: s.acc + 5});
    endfunction

    function automatic void model_edge();
        bit rdy_before;
        rdy_before = (cyc - 1 >= run_edge);
        if (rst) begin
            q.delete();
            pend_v   = 1'b0;
            run_edge = cyc + N + 1;
            for (int c = 0; c < N; c++) integ[c] = 0;
        end else begin
            if (bus.integ_clear && rdy_before) integ[int'(bus.integ_clear_ch)] = 0;
            if (pend_v) integrate(pend);
            pend_v = bus.in_valid && rdy_before;
            pend.ch  = int'(bus.in_ch);
            pend.e   = longint'(bus.actual) - longint'(bus.setpoint);
            pend.kp  = longint'(bus.kp);
            pend.ki  = longint'(bus.ki);
            pend.lo  = longint'(bus.sat_lower);
            pend.hi  = longint'(bus.sat_upper);
`ifdef PI_INTEGRATOR_CLAMP_EN
            pend.ilo = longint'(bus.integ_lower);
            pend.ihi = longint'(bus.integ_upper);
`else
            pend.ilo = IMIN;
            pend.ihi = IMAX;
`endif
            pend.acc = cyc;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        n_vec++;
        if (bus.in_ready !== (cyc >= run_edge)) begin
            n_err++;
            $display("FAIL in_ready cyc=%0d got=%b want=%b", cyc, bus.in_ready, (cyc >= run_edge));
        end
    endtask

    task automatic send(input int ch, input int sp, input int act, input int kp, input int ki,
                        input int lo, input int hi);
        bus.in_valid  = 1'b1;
        bus.in_ch     = CHW'(ch);
        bus.setpoint  = IW'(sp);
        bus.actual    = IW'(act);
        bus.kp        = OW'(kp);
        bus.ki        = OW'(ki);
        bus.sat_lower = OW'(lo);
        bus.sat_upper = OW'(hi);
        step();
        bus.in_valid    = 1'b0;
        bus.integ_clear = 1'b0;
    endtask

    task automatic clear_ch(input int ch);
        bus.integ_clear    = 1'b1;
        bus.integ_clear_ch = CHW'(ch);
        step();
        bus.integ_clear = 1'b0;
    endtask

    task automatic check_out0(input string tag);
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.out_ch !== '0 || bus.pi_result !== '0 ||
            bus.integral_result !== '0) begin
            n_err++;
            $display("FAIL %s outputs v=%b ch=%0d pi=%0d integ=%0d, want all 0", tag,
                     bus.out_valid, bus.out_ch, bus.pi_result, bus.integral_result);
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out cyc=%0d ch=%0d pi=%0d", cyc, bus.out_ch, bus.pi_result);
            end else begin
                mx = q.pop_front();
                if (int'(bus.out_ch) != mx.ch || longint'(bus.pi_result) != mx.pi ||
                    longint'(bus.integral_result) != mx.integ || cyc != mx.due) begin
                    n_err++;
                    $display("FAIL result got ch=%0d pi=%0d integ=%0d cyc=%0d want ch=%0d pi=%0d integ=%0d cyc=%0d",
                             bus.out_ch, bus.pi_result, bus.integral_result, cyc,
                             mx.ch, mx.pi, mx.integ, mx.due);
                end
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            n_vec++;
            n_err++;
            mx = q.pop_front();
            $display("FAIL missing_out cyc=%0d want ch=%0d pi=%0d", cyc, mx.ch, mx.pi);
        end
    end

    task automatic f4_check(input int sp, input int act, input int kp,
                            input longint want_pi, input longint want_i);
        bit seen;
        seen = 1'b0;
        bus4.setpoint = IW'(sp);
        bus4.actual   = IW'(act);
        bus4.kp       = OW'(kp);
        bus4.in_valid = 1'b1;
        n_vec++;
        if (bus4.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL f4_ready got=%b want=1", bus4.in_ready);
        end
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bus4.out_valid === 1'b1) begin
                seen = 1'b1;
                n_vec++;
                if (k != 5 || longint'(bus4.pi_result) != want_pi ||
                    longint'(bus4.integral_result) != want_i) begin
                    n_err++;
                    $display("FAIL frac4 got pi=%0d integ=%0d lat=%0d want pi=%0d integ=%0d lat=5",
                             bus4.pi_result, bus4.integral_result, k, want_pi, want_i);
                end
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL frac4_timeout no out_valid, want pi=%0d", want_pi);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        pend_v = 1'b0;
        run_edge = 32'h3fff_ffff;
        for (int c = 0; c < N; c++) integ[c] = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_ch = '0; bus.setpoint = '0; bus.actual = '0;
        bus.kp = '0; bus.ki = '0; bus.sat_lower = '0; bus.sat_upper = '0;
        bus.integ_clear = 1'b0; bus.integ_clear_ch = '0;
        bus4.in_valid = 1'b0; bus4.in_ch = '0; bus4.setpoint = '0; bus4.actual = '0;
        bus4.kp = '0; bus4.ki = '0; bus4.sat_lower = 32'sh8000_0000; bus4.sat_upper = 32'sh7fff_ffff;
        bus4.integ_clear = 1'b0; bus4.integ_clear_ch = '0;
`ifdef PI_INTEGRATOR_CLAMP_EN
        bus.integ_lower = 32'sh8000_0000; bus.integ_upper = 32'sh7fff_ffff;
        bus4.integ_lower = 32'sh8000_0000; bus4.integ_upper = 32'sh7fff_ffff;
`endif

        // Reset and init sweep; in_ready is checked at every step.
        repeat (3) step();
        check_out0("reset");
        rst = 1'b0;
        repeat (N + 1) step();
        check_out0("post_sweep");

        send(0, 100, 110, 2, 1, -1000, 1000);
        send(0, 100, 110, 2, 1, -1000, 1000);
        repeat (6) step();

        clear_ch(0);
        for (int k = 0; k < 4; k++) send(k % 2, 0, 5, 0, 1, -1000, 1000);
        repeat (6) step();

        send(2, 0, 32'h10000, 9, 0, -32'h80000, 32'h7ffff);
        send(2, 0, -32'h10000, 9, 0, -32'h80000, 32'h7ffff);
        send(3, 0, 40, 1, 0, 100, -100);
        repeat (6) step();

        send(1, 0, 4, 0, 1, -1000, 1000);
        step();
        bus.integ_clear = 1'b1; bus.integ_clear_ch = 2'd1;
        send(1, 0, -3, 0, 1, -1000, 1000);
        send(1, 0, 10, 0, 1, -1000, 1000);
        clear_ch(1);
        repeat (6) step();

`ifdef PI_INTEGRATOR_CLAMP_EN
        clear_ch(3);
        bus.integ_lower = -32'sd1000; bus.integ_upper = 32'sd50;
        repeat (4) send(3, 0, 20, 0, 1, -1000, 1000);
        repeat (6) step();
        bus.integ_lower = 32'sh8000_0000; bus.integ_upper = 32'sh7fff_ffff;
`endif

        // Reset while samples are in flight, then again mid-sweep (with a clear to be ignored).
        send(0, 0, 7, 1, 1, -1000, 1000);
        send(1, 0, 8, 1, 1, -1000, 1000);
        send(2, 0, 9, 1, 1, -1000, 1000);
        step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();
        bus.integ_clear = 1'b1; bus.integ_clear_ch = 2'd0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (N + 1) step();
        bus.integ_clear = 1'b0;

        // Integrator saturation at both rails.
        for (int k = 0; k < 8300; k++) send(2, -131072, 131071, 1, 1, 32'h8000_0000, 32'h7fff_ffff);
        clear_ch(2);
        for (int k = 0; k < 8300; k++) send(2, 131071, -131072, 1, 1, 32'h8000_0000, 32'h7fff_ffff);
        repeat (6) step();

        for (int n = 0; n < 3000; n++) begin
            int ch, sp, act, kp, ki, lo, hi;
            ch = int'($urandom_range(0, N - 1));
            sp = int'($urandom_range(0, 200000)) - 100000;
            if ($urandom_range(0, 1) == 1) act = sp + int'($urandom_range(0, 2000)) - 1000;
            else act = int'($urandom_range(0, 262143)) - 131072;
            kp = int'($urandom_range(0, 8192)) - 4096;
            ki = int'($urandom_range(0, 8192)) - 4096;
            if ($urandom_range(0, 7) == 0) begin
                lo = int'($urandom);
                hi = int'($urandom);
            end else begin
                lo = -int'($urandom_range(0, 1 << 30));
                hi = int'($urandom_range(0, 1 << 30));
            end
`ifdef PI_INTEGRATOR_CLAMP_EN
            if ($urandom_range(0, 3) == 0) begin
                bus.integ_lower = OW'(-int'($urandom_range(0, 100000)));
                bus.integ_upper = OW'(int'($urandom_range(0, 100000)));
            end
`endif
            if ($urandom_range(0, 7) == 0) begin
                bus.integ_clear    = 1'b1;
                bus.integ_clear_ch = CHW'($urandom_range(0, N - 1));
            end
            if ($urandom_range(0, 3) != 0) begin
                send(ch, sp, act, kp, ki, lo, hi);
            end else begin
                step();
                bus.integ_clear = 1'b0;
            end
        end

        for (int k = 0; k < 20 && q.size() != 0; k++) step();
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout pending=%0d want 0", q.size());
        end

        f4_check(0, 7, 16, 7, 7);
        f4_check(0, -7, 16, -7, 0);
        f4_check(0, -1, 1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
